conv_input_replay_buffer: RTL
=============================

Name: conv_input_replay_buffer

Overview:
- Upstream stage of the 3x3 conv layer top. Captures one complete input feature map (IMAGE_WIDTH x IMAGE_HEIGHT x CHANNEL_NUM_IN words) into on-chip RAM.
- Replays the stored map CHANNEL_NUM_OUT times, once per output channel, as a gap-free valid/data stream for the conv engine.
- Flags input words that arrive while replaying and discards them.

Parameters:
- DATA_WIDTH, 32, word width (fp32 pixel).
- IMAGE_WIDTH, 64, feature-map width.
- IMAGE_HEIGHT, 64, feature-map height.
- CHANNEL_NUM_IN, 64, input channels stored.
- CHANNEL_NUM_OUT, 256, number of replay passes.
- GAP_CYCLES, 0, idle cycles inserted between passes (conv line-buffer flush).
- MAP_WORDS, IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM_IN, derived; depth of the RAM.
- ADDR_WIDTH, clog2(MAP_WORDS), derived.
- PASS_WIDTH, clog2(CHANNEL_NUM_OUT)+1, derived.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- valid_in  in  1  input word strobe.
- pxl_in  in  DATA_WIDTH  input word; channel-planar order (ch0 raster, then ch1, ...).
- load_ready  out  1  high in LOAD state; words are accepted only while high.
- pxl_out  out  DATA_WIDTH  replayed word.
- valid_out  out  1  replay word strobe.
- pass_idx  out  PASS_WIDTH  current output-channel pass, 0..CHANNEL_NUM_OUT-1.
- map_done  out  1  one-cycle pulse with the last word of the last pass.
- overflow  out  1  sticky; set by valid_in outside LOAD; cleared only by reset.

Behaviour:
- All outputs are registered. Reset values: pxl_out=0, valid_out=0, pass_idx=0, map_done=0, overflow=0, load_ready=1. Reset also clears the state to LOAD and all counters to 0.
- Reset mid-operation aborts the current pass immediately. RAM contents are don't-care after reset.
- States: LOAD, REPLAY, GAP.
- LOAD:
  - Each valid_in writes pxl_in to RAM[wr_addr], then wr_addr++.
  - When the write at wr_addr=MAP_WORDS-1 is taken: wr_addr->0, next state REPLAY.
  - Gaps in valid_in are allowed; there is no timeout.
- REPLAY:
  - Issues one read per cycle, rd_addr 0..MAP_WORDS-1. The RAM is synchronous read with 1-cycle latency.
  - valid_out/pxl_out appear 1 cycle after the read is issued, so valid_out is continuous for MAP_WORDS cycles per pass.
  - Latency: last load word accepted at cycle T -> first valid_out at T+2.
- End of pass (read of MAP_WORDS-1 issued):
  - If pass_cnt=CHANNEL_NUM_OUT-1: next state LOAD. map_done asserts together with that pass's final valid_out. pass_cnt->0.
  - Otherwise pass_cnt++. Next state is GAP if GAP_CYCLES>0, else REPLAY with rd_addr=0, giving back-to-back passes with no bubble.
- GAP: holds GAP_CYCLES cycles with valid_out=0, then enters REPLAY.
- pass_idx is the pass number of the word currently on pxl_out. It is registered alongside valid_out and updates with the first word of each pass.
- load_ready rises in the cycle after the final valid_out of the last pass. A new map can then be written; the next replay starts from the new contents.
- valid_in outside LOAD: the word is dropped, RAM and counters are unchanged, and overflow sets.
- pxl_out holds its last value while valid_out=0.
- Counters are sized so no wrap occurs before the explicit terminal compares.

Decomposition:
- Shared package/header holds the derived constants (MAP_WORDS, ADDR_WIDTH, PASS_WIDTH), the clog2 function and the state encodings. It sits beside the existing conv_3x3 parameter definitions.
- One sub-module: conv_replay_ram, a simple dual-port RAM (1 write port, 1 synchronous read port, DATA_WIDTH x MAP_WORDS) inferable as BRAM.
- FSM and counters live in the top.

Test Plan:
- Params 2x2, CIN=2, COUT=3, GAP=0. Load words 1..8 -> 24 consecutive valid_out cycles with values 1..8,1..8,1..8. pass_idx is 0,1,2 per block. map_done on cycle 24 only. First valid_out exactly 2 cycles after word 8.
- Same params, GAP_CYCLES=2 -> two 2-cycle valid_out=0 bubbles between passes, and no bubble after the last pass. Total 24 valid words.
- Load with valid_in toggling 1,0,1,0 -> identical output sequence; load_ready stays 1 until the 8th accepted word.
- Pulse valid_in with value 99 during REPLAY -> overflow=1 and stays 1. Output sequence unchanged (99 never appears).
- Assert reset in pass 1 after 3 words -> next cycle valid_out=0, pass_idx=0, load_ready=1. Reload 11..18 -> replays 11..18 three times.
- Two back-to-back maps (1..8, then 21..28 written after load_ready rises) -> second map_done follows 24 words of 21..28.

Source files
------------

// File: rtl/conv_input_replay_buffer_pkg.sv
`default_nettype none
// conv_input_replay_buffer_pkg : shared constants, sizing helpers and state encodings
// for the conv_3x3 input replay stage (rev 1.0)

package conv_input_replay_buffer_pkg;

  // Default geometry of the conv_3x3 layer this buffer feeds
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_IMAGE_WIDTH     = 64;
  localparam int DEF_IMAGE_HEIGHT    = 64;
  localparam int DEF_CHANNEL_NUM_IN  = 64;
  localparam int DEF_CHANNEL_NUM_OUT = 256;
  localparam int DEF_GAP_CYCLES      = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int map_words(input int width, input int height, input int chans);
    return width * height * chans;
  endfunction

  function automatic int pass_width(input int passes);
    return clog2(passes) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_REPLAY = 2'd1,
    ST_GAP    = 2'd2
  } replay_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_replay_ram.sv
`default_nettype none
// conv_replay_ram : simple dual-port RAM, one write port and one registered read port,
// shaped for block-RAM inference (rev 1.0)

module conv_replay_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register only loads on a read, so it holds between replay words
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_input_replay_buffer.sv
`default_nettype none
// conv_input_replay_buffer : captures one input feature map, then replays it once per
// output channel as a gap-free stream for the conv engine (rev 1.0)

module conv_input_replay_buffer
  import conv_input_replay_buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int MAP_WORDS       = map_words(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_IN),
  parameter int ADDR_WIDTH      = clog2(MAP_WORDS),
  parameter int PASS_WIDTH      = pass_width(CHANNEL_NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  load_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic [PASS_WIDTH-1:0] pass_idx,
  output logic                  map_done,
  output logic                  overflow
);

  localparam int GAP_WIDTH = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MAP_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [PASS_WIDTH-1:0] PASS_LAST = PASS_WIDTH'(CHANNEL_NUM_OUT - 1);
  localparam logic [PASS_WIDTH-1:0] PASS_ONE  = PASS_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_LAST  = GAP_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE   = GAP_WIDTH'(1);

  replay_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PASS_WIDTH-1:0] pass_cnt;
  logic [GAP_WIDTH-1:0]  gap_cnt;

  logic accept;
  logic wr_last;
  logic rd_en;
  logic rd_last;
  logic pass_last;
  logic gap_last;

  // load_ready is only ever high while the state is LOAD, so it alone gates writes
  assign accept    = valid_in & load_ready;
  assign wr_last   = (wr_addr == ADDR_LAST);
  assign rd_last   = (rd_addr == ADDR_LAST);
  assign pass_last = (pass_cnt == PASS_LAST);
  assign gap_last  = (gap_cnt == GAP_LAST);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    unique case (state)
      ST_LOAD: begin
        if (accept && wr_last) state_nxt = ST_REPLAY;
      end
      ST_REPLAY: begin
        rd_en = 1'b1;
        if (rd_last) begin
          if (pass_last) begin
            state_nxt = ST_LOAD;
          end else if (GAP_CYCLES > 0) begin
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_last) state_nxt = ST_REPLAY;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      pass_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (accept) begin
        wr_addr <= wr_last ? '0 : wr_addr + ADDR_ONE;
      end
      if (rd_en) begin
        rd_addr <= rd_last ? '0 : rd_addr + ADDR_ONE;
      end
      if (rd_en && rd_last) begin
        pass_cnt <= pass_last ? '0 : pass_cnt + PASS_ONE;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_last ? '0 : gap_cnt + GAP_ONE;
      end
    end
  end

  // Stream flags ride one cycle behind the read so they line up with the RAM output.
  // load_ready returns one cycle after re-entering LOAD, i.e. after the final word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      pass_idx   <= '0;
      map_done   <= 1'b0;
      overflow   <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      valid_out  <= rd_en;
      map_done   <= rd_en & rd_last & pass_last;
      load_ready <= (state == ST_LOAD) && (state_nxt == ST_LOAD);
      if (rd_en) begin
        pass_idx <= pass_cnt;
      end
      if (valid_in && !load_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  conv_replay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAP_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (pxl_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (pxl_out)
  );

endmodule

`default_nettype wire
